// File: rtl/storage_controller.sv
// rtl/storage_controller.sv - SRAM/serial-flash memory front end with SPI programming passthrough
module storage_controller #(
  parameter int SRAM_WORDS = 4096,
  parameter int SPI_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_access,
  input  logic        memory_is_writing,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic [3:0]  mem_be,
  input  logic        set_programming_mode,
  input  logic        external_storage_spi_miso,
  input  logic        programming_spi_cs_n,
  input  logic        programming_spi_sck,
  input  logic        programming_spi_mosi,
  output logic [31:0] d_out,
  output logic        out_valid,
  output logic        external_storage_spi_cs_n,
  output logic        external_storage_spi_sck,
  output logic        external_storage_spi_mosi,
  output logic        programming_spi_miso
);

  localparam int AW = $clog2(SRAM_WORDS);
  localparam int DW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   mem [SRAM_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   sram_word;
  logic [31:0]   merged;
  logic          sram_hit;
  logic          accept;
  logic          ext_start;
  logic          busy;

  logic [DW-1:0] div_cnt;
  logic          sck_q;
  logic [31:0]   tx_q;
  logic [31:0]   rx_q;
  logic [5:0]    bit_cnt;
  logic          tick;
  logic          fall_tick;

  logic          spi_cs_n_int;
  logic          spi_mosi_int;

  // Requests are only taken while idle and never in programming mode
  assign sram_hit  = (addr < 32'(SRAM_WORDS));
  assign accept    = (state == S_IDLE) && memory_access && !set_programming_mode;
  assign ext_start = accept && !sram_hit && !memory_is_writing;
  assign idx       = addr[AW-1:0];
  assign sram_word = mem[idx];
  assign busy      = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);

  // The divider reaching its terminal count toggles sck; sck high at that point means a falling edge
  assign tick      = busy && (div_cnt == DW'(SPI_DIV - 1));
  assign fall_tick = tick && sck_q;

  // Byte-enable merge of new write data over the currently stored word
  always_comb begin
    merged = sram_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) begin
        merged[8*b +: 8] = d_in[8*b +: 8];
      end
    end
  end

  // SRAM array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (rst && accept && sram_hit && memory_is_writing) begin
      mem[idx] <= merged;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Flash read sequencing plus the internally generated cs_n/mosi
  always_comb begin
    state_nxt    = state;
    spi_cs_n_int = 1'b1;
    spi_mosi_int = 1'b0;
    if (busy) begin
      spi_cs_n_int = 1'b0;
    end
    if ((state == S_CMD) || (state == S_ADDR)) begin
      spi_mosi_int = tx_q[31];
    end
    if (set_programming_mode) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (ext_start) state_nxt = S_CMD;
        S_CMD:  if (fall_tick && (bit_cnt == 6'd7))  state_nxt = S_ADDR;
        S_ADDR: if (fall_tick && (bit_cnt == 6'd31)) state_nxt = S_DATA;
        S_DATA: if (fall_tick && (bit_cnt == 6'd63)) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // SPI mode-0 shifter: sample miso as sck rises, advance mosi as sck falls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_cnt <= '0;
    end else if (ext_start) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
      tx_q    <= {8'h03, 24'((addr - 32'(SRAM_WORDS)) << 2)};
      bit_cnt <= '0;
    end else if (set_programming_mode || !busy) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sck_q   <= !sck_q;
      if (!sck_q) begin
        if (state == S_DATA) begin
          rx_q <= {rx_q[30:0], external_storage_spi_miso};
        end
      end else begin
        tx_q    <= {tx_q[30:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Completion: SRAM and external writes finish on the access edge, flash reads in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (sram_hit) begin
          d_out     <= memory_is_writing ? merged : sram_word;
          out_valid <= 1'b1;
        end else if (memory_is_writing) begin
          out_valid <= 1'b1;
        end
      end else if ((state == S_DONE) && !set_programming_mode) begin
        // flash bytes arrive lowest address first
        d_out     <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
        out_valid <= 1'b1;
      end
    end
  end

  // Pin mux: programming mode wires the programmer straight to the flash, reset or not
  always_comb begin
    if (set_programming_mode) begin
      external_storage_spi_cs_n = programming_spi_cs_n;
      external_storage_spi_sck  = programming_spi_sck;
      external_storage_spi_mosi = programming_spi_mosi;
      programming_spi_miso      = external_storage_spi_miso;
    end else begin
      external_storage_spi_cs_n = spi_cs_n_int;
      external_storage_spi_sck  = sck_q;
      external_storage_spi_mosi = spi_mosi_int;
      programming_spi_miso      = 1'b0;
    end
  end

endmodule

// File: tb/tb_storage_controller.sv
// tb/tb_storage_controller.sv - self-checking bench for storage_controller
module tb_storage_controller;

  localparam int SW  = 4096;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_access;
  logic        memory_is_writing;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [3:0]  mem_be;
  logic        set_programming_mode;
  logic        ext_miso;
  logic        programming_spi_cs_n;
  logic        programming_spi_sck;
  logic        programming_spi_mosi;
  logic [31:0] d_out;
  logic        out_valid;
  logic        ext_cs_n;
  logic        ext_sck;
  logic        ext_mosi;
  logic        programming_spi_miso;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [SW];
  logic [7:0]  flash [256];
  logic [31:0] exp_dout;

  logic        pt_test = 1'b0;
  logic        pt_miso = 1'b0;
  logic        fl_miso = 1'b0;
  logic [31:0] fl_cmd  = '0;
  int          fl_bits = 0;
  logic [7:0]  fl_byte;

  always #5 clk = ~clk;

  storage_controller #(.SRAM_WORDS(SW), .SPI_DIV(DIV)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .memory_access             (memory_access),
    .memory_is_writing         (memory_is_writing),
    .addr                      (addr),
    .d_in                      (d_in),
    .mem_be                    (mem_be),
    .set_programming_mode      (set_programming_mode),
    .external_storage_spi_miso (ext_miso),
    .programming_spi_cs_n      (programming_spi_cs_n),
    .programming_spi_sck       (programming_spi_sck),
    .programming_spi_mosi      (programming_spi_mosi),
    .d_out                     (d_out),
    .out_valid                 (out_valid),
    .external_storage_spi_cs_n (ext_cs_n),
    .external_storage_spi_sck  (ext_sck),
    .external_storage_spi_mosi (ext_mosi),
    .programming_spi_miso      (programming_spi_miso)
  );

  assign ext_miso = pt_test ? pt_miso : fl_miso;

  // Serial flash: captures command+address on sck rise, serves bytes from its array on sck fall
  always @(posedge ext_sck or posedge ext_cs_n) begin
    if (ext_cs_n) begin
      fl_bits <= 0;
    end else begin
      if (fl_bits < 32) fl_cmd <= {fl_cmd[30:0], ext_mosi};
      fl_bits <= fl_bits + 1;
    end
  end

  always @(negedge ext_sck) begin
    if (!ext_cs_n && fl_bits >= 32 && fl_bits < 64) begin
      fl_byte = flash[8'(int'(fl_cmd[7:0]) + (fl_bits - 32) / 8)];
      fl_miso <= fl_byte[7 - ((fl_bits - 32) % 8)];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ext_exp(input logic [31:0] a);
    logic [7:0] b;
    b = 8'((a - SW) * 4);
    return {flash[b + 8'd3], flash[b + 8'd2], flash[b + 8'd1], flash[b]};
  endfunction

  task automatic sram_op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    memory_access     = 1'b1;
    memory_is_writing = we;
    addr              = a;
    d_in              = d;
    mem_be            = be;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[a[11:0]][8*b +: 8] = d[8*b +: 8];
      end
    end
    exp_dout = ref_mem[a[11:0]];
    step();
    memory_access = 1'b0;
    check(we ? "sram_wr_valid" : "sram_rd_valid", {31'b0, out_valid}, 32'd1);
    check(we ? "sram_wr_data" : "sram_rd_data", d_out, exp_dout);
  endtask

  task automatic wait_done(input string tag);
    int waited;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 1000) begin
      step();
      waited++;
    end
    check({tag, "_done"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic ext_read(input logic [31:0] a, input string tag);
    int pulses;
    exp_dout          = ext_exp(a);
    memory_access     = 1'b1;
    memory_is_writing = 1'b0;
    addr              = a;
    step();
    memory_access = 1'b0;
    check({tag, "_cs_active"}, {31'b0, ext_cs_n}, 32'd0);
    wait_done(tag);
    check({tag, "_data"}, d_out, exp_dout);
    check({tag, "_cmd"}, fl_cmd, {8'h03, 24'((a - SW) * 4)});
    check({tag, "_cs_idle"}, {31'b0, ext_cs_n}, 32'd1);
    pulses = 0;
    repeat (5) begin
      step();
      if (out_valid) pulses++;
    end
    check({tag, "_single_pulse"}, 32'(pulses), 32'd0);
    check({tag, "_sck_idle"}, {31'b0, ext_sck}, 32'd0);
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    rst                  = 1'b1;
    memory_access        = 1'b0;
    memory_is_writing    = 1'b0;
    addr                 = '0;
    d_in                 = '0;
    mem_be               = '0;
    set_programming_mode = 1'b1;
    programming_spi_cs_n = 1'b1;
    programming_spi_sck  = 1'b0;
    programming_spi_mosi = 1'b0;
    exp_dout             = '0;
    for (int i = 0; i < 256; i++) flash[i] = 8'($urandom);
    #2 rst = 1'b0;

    // passthrough while held in reset
    for (int v = 0; v < 8; v++) begin
      {programming_spi_mosi, programming_spi_sck, programming_spi_cs_n} = 3'(v);
      #1;
      check("pt_pins", {29'b0, ext_mosi, ext_sck, ext_cs_n}, 32'(v));
    end
    pt_test = 1'b1;
    pt_miso = 1'b0;
    #1 check("pt_miso0", {31'b0, programming_spi_miso}, 32'd0);
    pt_miso = 1'b1;
    #1 check("pt_miso1", {31'b0, programming_spi_miso}, 32'd1);
    rst = 1'b1;
    programming_spi_cs_n = 1'b1;
    programming_spi_sck  = 1'b0;
    programming_spi_mosi = 1'b0;

    // programming mode ignores memory requests
    memory_access = 1'b1;
    addr          = 32'd0;
    repeat (3) begin
      step();
      check("pt_no_valid", {31'b0, out_valid}, 32'd0);
    end
    memory_access = 1'b0;

    // normal-mode reset state
    set_programming_mode = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_dout", d_out, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_spi", {29'b0, ext_cs_n, ext_sck, ext_mosi}, 32'b100);
    check("norm_miso_zero", {31'b0, programming_spi_miso}, 32'd0);
    step();
    rst = 1'b1;
    pt_test = 1'b0;
    step();
    check("post_rst_dout", d_out, 32'd0);
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);

    // full SRAM sweep: write then idle, then back-to-back reads
    for (int i = 0; i < SW; i++) begin
      sram_op(1'b1, 32'(i), 32'(i), 4'hF);
      step();
      check("sweep_idle_valid", {31'b0, out_valid}, 32'd0);
      check("sweep_idle_hold", d_out, 32'(i));
    end
    for (int i = 0; i < SW; i++) begin
      sram_op(1'b0, 32'(i), 32'h0, 4'h0);
    end

    // byte enables
    sram_op(1'b1, 32'd5, 32'hFFFF_FFFF, 4'hF);
    sram_op(1'b1, 32'd5, 32'h1234_5678, 4'b0101);
    sram_op(1'b0, 32'd5, 32'h0, 4'h0);
    check("be_merge", d_out, 32'hFF34_FF78);

    // randomized SRAM traffic against the reference array
    repeat (300) begin
      sram_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, SW - 1)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        step();
        check("rand_idle_valid", {31'b0, out_valid}, 32'd0);
        check("rand_idle_hold", d_out, exp_dout);
      end
    end

    // directed flash read
    flash[8]  = 8'hEF;
    flash[9]  = 8'hBE;
    flash[10] = 8'hAD;
    flash[11] = 8'hDE;
    ext_read(32'(SW + 2), "ext_deadbeef");
    check("ext_deadbeef_const", d_out, 32'hDEAD_BEEF);
    check("ext_deadbeef_cmd_const", fl_cmd, 32'h0300_0008);

    // external-range write: pulse only, d_out untouched, no SPI activity
    memory_access     = 1'b1;
    memory_is_writing = 1'b1;
    addr              = 32'(SW + 7);
    d_in              = $urandom;
    mem_be            = 4'hF;
    step();
    memory_access = 1'b0;
    check("extwr_valid", {31'b0, out_valid}, 32'd1);
    check("extwr_hold", d_out, exp_dout);
    check("extwr_cs", {31'b0, ext_cs_n}, 32'd1);
    step();
    check("extwr_pulse_end", {31'b0, out_valid}, 32'd0);

    // randomized flash reads
    repeat (6) begin
      ext_read(32'(SW + $urandom_range(0, 60)), "ext_rand");
    end

    // requests during a flash read are dropped
    a                 = 32'(SW + 1);
    exp_dout          = ext_exp(a);
    memory_access     = 1'b1;
    memory_is_writing = 1'b0;
    addr              = a;
    step();
    memory_is_writing = 1'b1;
    addr              = 32'd100;
    d_in              = ~ref_mem[100];
    mem_be            = 4'hF;
    step();
    memory_access = 1'b0;
    check("busy_no_valid", {31'b0, out_valid}, 32'd0);
    wait_done("busy");
    check("busy_data", d_out, exp_dout);
    sram_op(1'b0, 32'd100, 32'h0, 4'h0);

    // abort by entering programming mode
    memory_access     = 1'b1;
    memory_is_writing = 1'b0;
    addr              = 32'(SW + 5);
    step();
    memory_access = 1'b0;
    repeat (40) step();
    check("abort_pm_busy", {31'b0, ext_cs_n}, 32'd0);
    set_programming_mode = 1'b1;
    programming_spi_cs_n = 1'b0;
    #1 check("abort_pm_cs_follow0", {31'b0, ext_cs_n}, 32'd0);
    programming_spi_cs_n = 1'b1;
    #1 check("abort_pm_cs_follow1", {31'b0, ext_cs_n}, 32'd1);
    cnt = 0;
    repeat (300) begin
      step();
      if (out_valid) cnt++;
    end
    check("abort_pm_no_valid", 32'(cnt), 32'd0);
    set_programming_mode = 1'b0;
    #1 check("abort_pm_spi_idle", {29'b0, ext_cs_n, ext_sck, ext_mosi}, 32'b100);
    cnt = 0;
    repeat (300) begin
      step();
      if (out_valid) cnt++;
    end
    check("abort_pm_stays_idle", 32'(cnt), 32'd0);
    ext_read(32'(SW + 3), "ext_after_pm");

    // abort by reset
    memory_access = 1'b1;
    addr          = 32'(SW + 9);
    step();
    memory_access = 1'b0;
    repeat (60) step();
    rst = 1'b0;
    #1;
    check("abort_rst_dout", d_out, 32'd0);
    check("abort_rst_valid", {31'b0, out_valid}, 32'd0);
    check("abort_rst_spi", {29'b0, ext_cs_n, ext_sck, ext_mosi}, 32'b100);
    step();
    rst = 1'b1;
    cnt = 0;
    repeat (300) begin
      step();
      if (out_valid) cnt++;
    end
    check("abort_rst_no_valid", 32'(cnt), 32'd0);
    check("abort_rst_dout_hold", d_out, 32'd0);
    ext_read(32'(SW + 4), "ext_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
